// File: rtl/qsfp_tx_pkg.sv
// Shared definitions for the QSFP TX frame arbiter: FSM state encoding and
// the grant-index width helper.
package qsfp_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// Combinational round-robin picker: returns the first requesting port found
// searching upward from last_i+1, wrapping modulo N_PORTS.
module axis_rr_picker
  import qsfp_tx_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int IDX_W   = idx_width(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   idx_o
);

  localparam int SW = IDX_W + 1;

  logic [2*N_PORTS-1:0] req2;
  logic [N_PORTS-1:0]   rot;
  logic [SW-1:0]        off;
  logic [SW-1:0]        sum;

  // Doubling the request vector turns the wrap-around search into a plain shift.
  assign req2  = {req_i, req_i};
  assign rot   = N_PORTS'(req2 >> (SW'(last_i) + SW'(1)));
  assign any_o = |req_i;

  always_comb begin
    off = '0;
    for (int j = N_PORTS - 1; j >= 0; j--) begin
      if (rot[j]) off = SW'(j);
    end
    sum = SW'(last_i) + SW'(1) + off;
    if (sum >= SW'(N_PORTS)) sum = sum - SW'(N_PORTS);
    idx_o = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/qsfp_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter onto the single QSFP TX AXI-stream port.
// Grants hold until tlast; runaway frames are cut with tlast+tuser and drained.
module qsfp_tx_frame_arbiter
  import qsfp_tx_pkg::*;
#(
  parameter int N_PORTS         = 4,
  parameter int DATA_WIDTH      = 64,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int MAX_FRAME_BEATS = 1024,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            link_up,
  input  logic [N_PORTS-1:0]              s_axis_tvalid,
  input  logic [N_PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [N_PORTS*KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [N_PORTS-1:0]              s_axis_tlast,
  input  logic [N_PORTS-1:0]              s_axis_tuser,
  output logic [N_PORTS-1:0]              s_axis_tready,
  output logic                            m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tuser,
  input  logic                            m_axis_tready,
  output logic                            grant_valid,
  output logic [idx_width(N_PORTS)-1:0]   grant_idx,
  output logic [CNT_WIDTH-1:0]            trunc_count
);

  localparam int IDX_W  = idx_width(N_PORTS);
  localparam int BEAT_W = $clog2(MAX_FRAME_BEATS) + 1;
  localparam logic [BEAT_W-1:0] LIMIT_BEAT = BEAT_W'(MAX_FRAME_BEATS - 1);

  state_e               state_q;
  logic [IDX_W-1:0]     grant_idx_q;
  logic [IDX_W-1:0]     last_grant_q;
  logic [BEAT_W-1:0]    beat_cnt_q;
  logic [CNT_WIDTH-1:0] trunc_count_q;
  logic [CNT_WIDTH-1:0] trunc_count_d;

  logic [DATA_WIDTH-1:0] data_arr [N_PORTS];
  logic [KEEP_WIDTH-1:0] keep_arr [N_PORTS];

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_unpack
      assign data_arr[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign keep_arr[gi] = s_axis_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
    end
  endgenerate

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;

  axis_rr_picker #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i  (s_axis_tvalid),
    .last_i (last_grant_q),
    .any_o  (pick_any),
    .idx_o  (pick_idx)
  );

  logic in_pass, in_drain, sel_valid, sel_last, sel_user, at_limit, pass_hs;

  assign in_pass   = (state_q == ST_PASS);
  assign in_drain  = (state_q == ST_DRAIN);
  assign sel_valid = s_axis_tvalid[grant_idx_q];
  assign sel_last  = s_axis_tlast[grant_idx_q];
  assign sel_user  = s_axis_tuser[grant_idx_q];
  assign at_limit  = (beat_cnt_q == LIMIT_BEAT);
  assign pass_hs   = in_pass & sel_valid & m_axis_tready;

  // Zero-latency passthrough; a genuine tlast on the limit beat keeps its own tuser.
  assign m_axis_tvalid = in_pass & sel_valid;
  assign m_axis_tdata  = data_arr[grant_idx_q];
  assign m_axis_tkeep  = keep_arr[grant_idx_q];
  assign m_axis_tlast  = sel_last | at_limit;
  assign m_axis_tuser  = sel_user | (at_limit & ~sel_last);

  always_comb begin
    s_axis_tready = '0;
    if (in_pass)       s_axis_tready[grant_idx_q] = m_axis_tready;
    else if (in_drain) s_axis_tready[grant_idx_q] = 1'b1;
  end

  assign trunc_count_d = (&trunc_count_q) ? trunc_count_q : trunc_count_q + CNT_WIDTH'(1);
  assign grant_valid   = in_pass | in_drain;
  assign grant_idx     = grant_idx_q;
  assign trunc_count   = trunc_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_idx_q   <= '0;
      last_grant_q  <= IDX_W'(N_PORTS - 1);
      beat_cnt_q    <= '0;
      trunc_count_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (link_up && pick_any) begin
            grant_idx_q <= pick_idx;
            beat_cnt_q  <= '0;
            state_q     <= ST_PASS;
          end
        end
        ST_PASS: begin
          if (pass_hs) begin
            beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
            if (sel_last) begin
              last_grant_q <= grant_idx_q;
              state_q      <= ST_IDLE;
            end else if (at_limit) begin
              trunc_count_q <= trunc_count_d;
              state_q       <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (sel_valid && sel_last) begin
            last_grant_q <= grant_idx_q;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qsfp_tx_frame_arbiter.sv
// Randomized bench for qsfp_tx_frame_arbiter: per-port frame queues feed the DUT,
// a frame-level reference model is checked every cycle, plus literal pins.
module tb_qsfp_tx_frame_arbiter;

  localparam int N    = 4;
  localparam int DW   = 64;
  localparam int KW   = 8;
  localparam int MAXB = 4;
  localparam int CW   = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            link_up;
  logic [N-1:0]    s_tvalid, s_tlast, s_tuser, s_tready;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic            m_tvalid, m_tlast, m_tuser, m_tready;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            grant_valid;
  logic [1:0]      grant_idx;
  logic [CW-1:0]   trunc_count;

  always #5 clk = ~clk;

  qsfp_tx_frame_arbiter #(
    .N_PORTS(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .MAX_FRAME_BEATS(MAXB), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .link_up(link_up),
    .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
    .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .trunc_count(trunc_count)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  typedef struct {
    int          cyc;
    logic [63:0] data;
    logic        last;
    logic        user;
  } obeat_t;

  beat_t  src_q [N][$];
  beat_t  exp_frame[$];
  obeat_t out_log[$];
  int     grant_log[$];
  int     exp_g[$];

  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  bit  gap_en = 0;
  bit  bp_en = 0;
  bit  pop [N];

  // Reference model: phase 0 = no grant, 1 = forwarding, 2 = discarding the tail.
  int          ph, mp, mb, ml;
  logic [15:0] mt;
  bit          gv_prev;
  logic [N-1:0] e_ready;
  bit          e_mvalid, lim;
  obeat_t      ob;
  beat_t       drv_b;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      ph = 0; mp = 0; mb = 0; ml = N - 1; mt = '0; gv_prev = 0;
      for (int p = 0; p < N; p++) pop[p] = 0;
      chk("rst_tready", s_tready, 0);
      chk("rst_mvalid", m_tvalid, 0);
      chk("rst_gvalid", grant_valid, 0);
      chk("rst_gidx", grant_idx, 0);
      chk("rst_trunc", trunc_count, 0);
    end else begin
      e_ready = '0;
      if (ph == 1) e_ready[mp] = m_tready;
      else if (ph == 2) e_ready[mp] = 1'b1;
      e_mvalid = (ph == 1) && s_tvalid[mp];
      chk("gvalid", grant_valid, ph != 0);
      chk("gidx", grant_idx, mp);
      chk("tready", s_tready, e_ready);
      chk("mvalid", m_tvalid, e_mvalid);
      chk("trunc", trunc_count, mt);
      if (e_mvalid) begin
        lim = (mb == MAXB - 1);
        chk("tdata", m_tdata, s_tdata[mp*DW +: DW]);
        chk("tkeep", m_tkeep, s_tkeep[mp*KW +: KW]);
        chk("tlast", m_tlast, s_tlast[mp] || lim);
        chk("tuser", m_tuser, s_tuser[mp] || (lim && !s_tlast[mp]));
      end
      if (grant_valid && !gv_prev) grant_log.push_back(int'(grant_idx));
      gv_prev = grant_valid;
      if (m_tvalid && m_tready) begin
        ob.cyc = cyc; ob.data = m_tdata; ob.last = m_tlast; ob.user = m_tuser;
        out_log.push_back(ob);
      end
      for (int p = 0; p < N; p++) pop[p] = s_tvalid[p] && s_tready[p];
      case (ph)
        0: if (link_up && (|s_tvalid)) begin
             for (int k = 1; k <= N; k++) begin
               if (s_tvalid[(ml + k) % N]) begin mp = (ml + k) % N; break; end
             end
             mb = 0; ph = 1;
           end
        1: if (s_tvalid[mp] && m_tready) begin
             if (s_tlast[mp]) begin ml = mp; ph = 0; end
             else if (mb == MAXB - 1) begin
               mt = (mt == 16'hFFFF) ? mt : mt + 16'd1;
               ph = 2;
             end
             mb++;
           end
        2: if (s_tvalid[mp] && s_tlast[mp]) begin ml = mp; ph = 0; end
        default: ph = 0;
      endcase
    end
  end

  // Source/sink driver: updates inputs 1 time unit after each rising edge.
  initial begin
    s_tvalid = '0; s_tlast = '0; s_tuser = '0; s_tdata = '0; s_tkeep = '0; m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      for (int p = 0; p < N; p++) begin
        if (pop[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
        pop[p] = 0;
        if (src_q[p].size() > 0) begin
          drv_b = src_q[p][0];
          s_tvalid[p] = !gap_en || ($urandom_range(3) != 0);
          s_tdata[p*DW +: DW] = drv_b.data;
          s_tkeep[p*KW +: KW] = drv_b.keep;
          s_tlast[p] = drv_b.last;
          s_tuser[p] = drv_b.user;
        end else begin
          s_tvalid[p] = 1'b0;
          s_tlast[p]  = 1'b0;
          s_tuser[p]  = 1'b0;
          s_tdata[p*DW +: DW] = '0;
          s_tkeep[p*KW +: KW] = '0;
        end
      end
      m_tready = bp_en ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic push_frame(input int p, input int len, input int tag, input bit bad);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {8'(p), 8'(tag), 16'(i), 32'($urandom)};
      b.last = (i == len - 1);
      b.keep = b.last ? (8'hFF >> $urandom_range(7)) : 8'hFF;
      b.user = bad && b.last;
      src_q[p].push_back(b);
    end
  endtask

  function automatic bit all_empty();
    for (int p = 0; p < N; p++) if (src_q[p].size() != 0) return 0;
    return 1;
  endfunction

  task automatic wait_idle(input string nm);
    bit done = 0;
    for (int i = 0; i < 4000 && !done; i++) begin
      tick();
      done = all_empty() && (ph == 0);
    end
    chk({nm, "_done"}, done, 1);
  endtask

  task automatic clear_logs();
    out_log.delete();
    grant_log.delete();
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    for (int p = 0; p < N; p++) src_q[p].delete();
    gap_en = 0; bp_en = 0;
    repeat (2) tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic chk_grants(input string nm);
    chk({nm, "_count"}, grant_log.size(), exp_g.size());
    for (int i = 0; i < exp_g.size(); i++)
      chk(nm, (i < grant_log.size()) ? grant_log[i] : -1, exp_g[i]);
  endtask

  task automatic chk_frame_data(input string nm, input int n);
    for (int i = 0; i < n; i++)
      chk(nm, (i < out_log.size()) ? out_log[i].data : 64'hDEAD, exp_frame[i].data);
  endtask

  initial begin
    int n_long, n_out, len;
    bit ok;
    rst = 1'b1;
    link_up = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    clear_logs();

    // Two 3-beat frames on ports 0 and 2: no interleave, one bubble cycle.
    push_frame(0, 3, 1, 0);
    push_frame(2, 3, 2, 0);
    wait_idle("t1");
    chk("t1_nbeats", out_log.size(), 6);
    exp_g = {0, 2};
    chk_grants("t1_grant");
    if (out_log.size() >= 4) begin
      chk("t1_bubble", out_log[3].cyc - out_log[2].cyc, 2);
      chk("t1_port_f2", out_log[3].data[63:56], 2);
      chk("t1_last_f1", out_log[2].last, 1);
    end

    // Fairness: all ports valid, 1-beat frames.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++) push_frame(p, 1, 10 + r, 0);
    wait_idle("t2");
    exp_g = {0, 1, 2, 3, 0, 1, 2, 3};
    chk_grants("t2_rr");

    // Truncation of a 6-beat frame at the 4-beat limit.
    clear_logs();
    push_frame(1, 6, 3, 0);
    wait_idle("t3");
    chk("t3_nbeats", out_log.size(), 4);
    if (out_log.size() == 4) begin
      chk("t3_last", out_log[3].last, 1);
      chk("t3_user", out_log[3].user, 1);
      chk("t3_mid_last", out_log[2].last, 0);
    end
    chk("t3_trunc", trunc_count, 1);

    // Backpressure: genuine tlast on the limit beat, then a 5-beat truncated frame.
    bp_en = 1;
    clear_logs();
    push_frame(2, 4, 4, 0);
    exp_frame = src_q[2];
    wait_idle("t4a");
    chk("t4a_nbeats", out_log.size(), 4);
    chk_frame_data("t4a_data", 4);
    if (out_log.size() == 4) chk("t4a_user", out_log[3].user, 0);
    chk("t4a_trunc", trunc_count, 1);
    clear_logs();
    push_frame(3, 5, 5, 0);
    exp_frame = src_q[3];
    wait_idle("t4b");
    chk("t4b_nbeats", out_log.size(), 4);
    chk_frame_data("t4b_data", 4);
    chk("t4b_trunc", trunc_count, 2);
    bp_en = 0;

    // link_up gates new grants only.
    link_up = 1'b0;
    clear_logs();
    push_frame(3, 3, 6, 0);
    repeat (6) tick();
    chk("t5_nogrant", grant_valid, 0);
    chk("t5_noout", out_log.size(), 0);
    link_up = 1'b1;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin tick(); ok = grant_valid; end
    chk("t5_granted", ok, 1);
    chk("t5_gidx", grant_idx, 3);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin tick(); ok = (out_log.size() >= 1); end
    chk("t5_started", ok, 1);
    link_up = 1'b0;
    wait_idle("t5");
    chk("t5_nbeats", out_log.size(), 3);
    if (out_log.size() == 3) chk("t5_last", out_log[2].last, 1);
    link_up = 1'b1;

    // Reset mid-frame, then port 0 must win first.
    push_frame(1, 1, 7, 0);
    wait_idle("t6a");
    clear_logs();
    push_frame(2, 4, 8, 0);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin tick(); ok = (out_log.size() >= 1); end
    chk("t6_started", ok, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_tready", s_tready, 0);
    chk("t6_rst_mvalid", m_tvalid, 0);
    chk("t6_rst_gvalid", grant_valid, 0);
    for (int p = 0; p < N; p++) src_q[p].delete();
    repeat (2) tick();
    rst = 1'b0;
    clear_logs();
    for (int p = N - 1; p >= 0; p--) push_frame(p, 1, 9, 0);
    wait_idle("t6b");
    exp_g = {0, 1, 2, 3};
    chk_grants("t6_prio");
    chk("t6_trunc", trunc_count, 0);

    // Random stress: gaps, backpressure, mixed lengths (some over the limit).
    clear_logs();
    gap_en = 1; bp_en = 1;
    n_long = 0; n_out = 0;
    for (int f = 0; f < 60; f++) begin
      len = $urandom_range(6, 1);
      if (len > MAXB) n_long++;
      n_out += (len > MAXB) ? MAXB : len;
      push_frame($urandom_range(N - 1), len, 32 + f, ($urandom_range(7) == 0));
    end
    wait_idle("t7");
    chk("t7_trunc", trunc_count, n_long);
    chk("t7_nbeats", out_log.size(), n_out);
    gap_en = 0; bp_en = 0;

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
